// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, state encoding and the bus decode used by the UART send arbiter.
// The peripheral's register map is fixed here so the sequencer and its users agree on it.
package uart_tx_arbiter_pkg;

    localparam logic [3:0] UART_ADDR_DATA     = 4'h0;
    localparam logic [3:0] UART_ADDR_TX_STAT  = 4'h4;
    localparam logic [3:0] UART_ADDR_TX_START = 4'h8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        START   = 3'd2,
        GUARD   = 3'd3,
        POLL    = 3'd4,
        DONE    = 3'd5
    } state_e;

    typedef struct packed {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
    } bus_t;

    // Peripheral strobes are a pure function of the sequencer state.
    function automatic bus_t bus_decode(input state_e st, input logic [7:0] data);
        bus_t b;
        b = '0;
        case (st)
            WR_DATA: begin
                b.cs    = 1'b1;
                b.wr    = 1'b1;
                b.addr  = UART_ADDR_DATA;
                b.wdata = {8'h00, data};
            end
            START: begin
                b.cs   = 1'b1;
                b.wr   = 1'b1;
                b.addr = UART_ADDR_TX_START;
            end
            POLL: begin
                b.cs   = 1'b1;
                b.rd   = 1'b1;
                b.addr = UART_ADDR_TX_STAT;
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus peripheral register bus of the UART send arbiter.
// The master modport is the arbiter's view; slave is the requesters/peripheral side.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) ();

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] tx_byte;
    logic [N_REQ-1:0]   ack;
    logic               err;
    logic               busy;

    logic               cs;
    logic               rd;
    logic               wr;
    logic [3:0]         addr;
    logic [15:0]        wdata;
    logic [15:0]        rdata;

    modport master (
        input  req, tx_byte, rdata,
        output ack, err, busy, cs, rd, wr, addr, wdata
    );

    modport slave (
        output req, tx_byte, rdata,
        input  ack, err, busy, cs, rd, wr, addr, wdata
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping modulo N.
// Produces the grant both one-hot and as a binary index.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    logic [N-1:0] w_rot;
    logic [IW:0]  w_sum;

    // Bit k of w_rot is requester (i_ptr + k) mod N.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_any = 1'b0;
        w_sum = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            end
        end
        if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
        end
        o_gnt_idx = w_sum[IW-1:0];
        o_gnt     = o_any ? (N'(1) << o_gnt_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers: round-robin grant, then
// write data, pulse start, wait out the guard, poll busy until idle or timeout, ack.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned GUARD_CYC = 2,
    parameter int unsigned TO_W      = 16
) (
    input logic               i_clk,
    input logic               i_rst,
    uart_tx_arbiter_if.master io_bus
);

    localparam int unsigned    IW         = $clog2(N_REQ);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(N_REQ - 1);
    localparam logic [7:0]     GUARD_LAST = 8'(GUARD_CYC - 1);

    state_e             r_state, w_state_d;
    logic [IW-1:0]      r_grant, w_grant_d;
    logic [N_REQ-1:0]   r_grant_oh, w_grant_oh_d;
    logic [IW-1:0]      r_rr_ptr, w_rr_ptr_d;
    logic [7:0]         r_byte, w_byte_d;
    logic [7:0]         r_guard_cnt, w_guard_cnt_d;
    logic [TO_W-1:0]    r_to_cnt, w_to_cnt_d;
    logic               r_first, w_first_d;
    logic               r_timeout, w_timeout_d;

    logic [N_REQ-1:0]   r_ack, w_ack_d;
    logic               r_err, w_err_d;
    logic               r_busy, w_busy_d;
    bus_t               r_bus, w_bus_d;

    logic [N_REQ-1:0]   w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_any;
    logic [7:0]         w_sel_byte;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .i_req     (io_bus.req),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign w_sel_byte = 8'(io_bus.tx_byte >> {w_gnt_idx, 3'b000});

    always_comb begin
        w_state_d     = r_state;
        w_grant_d     = r_grant;
        w_grant_oh_d  = r_grant_oh;
        w_rr_ptr_d    = r_rr_ptr;
        w_byte_d      = r_byte;
        w_guard_cnt_d = r_guard_cnt;
        w_to_cnt_d    = r_to_cnt;
        w_first_d     = r_first;
        w_timeout_d   = r_timeout;

        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_d    = w_gnt_idx;
                    w_grant_oh_d = w_gnt;
                    w_byte_d     = w_sel_byte;
                    w_state_d    = WR_DATA;
                end
            end
            WR_DATA: w_state_d = START;
            START: begin
                w_guard_cnt_d = '0;
                w_state_d     = GUARD;
            end
            GUARD: begin
                if (r_guard_cnt == GUARD_LAST) begin
                    w_to_cnt_d = '0;
                    w_first_d  = 1'b1;
                    w_state_d  = POLL;
                end else begin
                    w_guard_cnt_d = r_guard_cnt + 8'd1;
                end
            end
            POLL: begin
                // The first read after entering POLL returns stale data.
                if (r_first) begin
                    w_first_d = 1'b0;
                end else if (!io_bus.rdata[0]) begin
                    w_state_d = DONE;
                end else begin
                    w_to_cnt_d = r_to_cnt + 1'b1;
                    if (&w_to_cnt_d) begin
                        w_timeout_d = 1'b1;
                        w_state_d   = DONE;
                    end
                end
            end
            DONE: begin
                w_rr_ptr_d  = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                w_timeout_d = 1'b0;
                w_state_d   = IDLE;
            end
            default: w_state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with r_state.
        w_ack_d  = (w_state_d == DONE) ? w_grant_oh_d : '0;
        w_err_d  = (w_state_d == DONE) && w_timeout_d;
        w_busy_d = (w_state_d != IDLE);
        w_bus_d  = bus_decode(w_state_d, w_byte_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_oh  <= '0;
            r_rr_ptr    <= '0;
            r_byte      <= '0;
            r_guard_cnt <= '0;
            r_to_cnt    <= '0;
            r_first     <= 1'b0;
            r_timeout   <= 1'b0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_bus       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_grant     <= w_grant_d;
            r_grant_oh  <= w_grant_oh_d;
            r_rr_ptr    <= w_rr_ptr_d;
            r_byte      <= w_byte_d;
            r_guard_cnt <= w_guard_cnt_d;
            r_to_cnt    <= w_to_cnt_d;
            r_first     <= w_first_d;
            r_timeout   <= w_timeout_d;
            r_ack       <= w_ack_d;
            r_err       <= w_err_d;
            r_busy      <= w_busy_d;
            r_bus       <= w_bus_d;
        end
    end

    assign io_bus.ack   = r_ack;
    assign io_bus.err   = r_err;
    assign io_bus.busy  = r_busy;
    assign io_bus.cs    = r_bus.cs;
    assign io_bus.rd    = r_bus.rd;
    assign io_bus.wr    = r_bus.wr;
    assign io_bus.addr  = r_bus.addr;
    assign io_bus.wdata = r_bus.wdata;

endmodule
